// File: rtl/cmp42_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp42_pkg : shared widths and the majority helper for the 4:2 row pipe     |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package cmp42_pkg;

  localparam int CMP42_W      = 64;
  localparam int CMP42_TAGW   = 4;
  localparam int CMP42_BEAT_W = 16;

  typedef logic [CMP42_BEAT_W-1:0] beat_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage : cmp42_pkg
`default_nettype wire

// File: rtl/cmp42_row_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp42_row_pipe_if : operand-in / redundant-result-out handshake bundle     |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
interface cmp42_row_pipe_if
  import cmp42_pkg::*;
#(
  parameter int W    = CMP42_W,
  parameter int TAGW = CMP42_TAGW
) ();

  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    row_a;
  logic [W-1:0]    row_b;
  logic [W-1:0]    row_c;
  logic [W-1:0]    row_d;
  logic [TAGW-1:0] in_tag;

  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum_row;
  logic [W-1:0]    carry_row;
  logic [TAGW-1:0] out_tag;

  // Producer/consumer side of the pipe (the environment around it).
  modport master (
    output in_valid, row_a, row_b, row_c, row_d, in_tag, out_ready,
    input  in_ready, out_valid, sum_row, carry_row, out_tag
  );

  // The pipe itself.
  modport slave (
    input  in_valid, row_a, row_b, row_c, row_d, in_tag, out_ready,
    output in_ready, out_valid, sum_row, carry_row, out_tag
  );

endinterface : cmp42_row_pipe_if
`default_nettype wire

// File: rtl/cmp42_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp42_bit : single-column 4:2 cell, no lateral carry                       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module cmp42_bit
  import cmp42_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic s_o,
  output logic ca_o,
  output logic co_o
);

  logic s_w;

  // a+b+c+d == s + 2*(ca + co) for every input combination of this column.
  assign s_w  = a_i ^ b_i ^ c_i ^ d_i;
  assign s_o  = s_w;
  assign ca_o = d_i & ~s_w;
  assign co_o = maj3(a_i, b_i, c_i);

endmodule : cmp42_bit
`default_nettype wire

// File: rtl/cmp42_row_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cmp42_row_pipe : two-stage 4-row to 2-row carry-save reducer with stalls   |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module cmp42_row_pipe
  import cmp42_pkg::*;
#(
  parameter int W    = CMP42_W,
  parameter int TAGW = CMP42_TAGW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cmp42_row_pipe_if.slave         bus,
  output logic [CMP42_BEAT_W-1:0] beat_cnt
);

  logic [W-1:0]    s_w;
  logic [W-1:0]    ca_w;
  logic [W-1:0]    co_w;

  logic            en1_w;
  logic            en2_w;

  logic            v1_q,    v1_d;
  logic [W-1:0]    x_q,     x_d;
  logic [W-1:0]    y_q,     y_d;
  logic [W-1:0]    z_q,     z_d;
  logic [TAGW-1:0] tag1_q,  tag1_d;

  logic            v2_q,    v2_d;
  logic [W-1:0]    sum_q,   sum_d;
  logic [W-1:0]    carry_q, carry_d;
  logic [TAGW-1:0] tag2_q,  tag2_d;

  beat_t           beat_q,  beat_d;

  for (genvar i = 0; i < W; i++) begin : g_cell
    cmp42_bit u_bit (
      .a_i  (bus.row_a[i]),
      .b_i  (bus.row_b[i]),
      .c_i  (bus.row_c[i]),
      .d_i  (bus.row_d[i]),
      .s_o  (s_w[i]),
      .ca_o (ca_w[i]),
      .co_o (co_w[i])
    );
  end

  // The only combinational input-to-output path: out_ready -> in_ready.
  assign en2_w        = ~v2_q | bus.out_ready;
  assign en1_w        = ~v1_q | en2_w;
  assign bus.in_ready = en1_w;

  always_comb begin
    v1_d    = v1_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    tag1_d  = tag1_q;
    v2_d    = v2_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    tag2_d  = tag2_q;
    beat_d  = beat_q;

    if (en1_w) begin
      v1_d = bus.in_valid;
      if (bus.in_valid) begin
        x_d    = s_w;
        y_d    = ca_w << 1;
        z_d    = co_w << 1;
        tag1_d = bus.in_tag;
      end
    end

    // Data registers only load with valid data, so a stalled result holds.
    if (en2_w) begin
      v2_d = v1_q;
      if (v1_q) begin
        sum_d   = x_q ^ y_q ^ z_q;
        carry_d = ((x_q & y_q) | (x_q & z_q) | (y_q & z_q)) << 1;
        tag2_d  = tag1_q;
      end
    end

    if (v2_q && bus.out_ready) begin
      beat_d = beat_q + beat_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      tag2_q  <= '0;
      beat_q  <= '0;
    end else begin
      v1_q    <= v1_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      tag1_q  <= tag1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      tag2_q  <= tag2_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.sum_row   = sum_q;
  assign bus.carry_row = carry_q;
  assign bus.out_tag   = tag2_q;
  assign beat_cnt      = beat_q;

endmodule : cmp42_row_pipe
`default_nettype wire

// File: tb/tb_cmp42_row_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cmp42_row_pipe : vector table on W=8, scoreboard + random on W=64       |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_cmp42_row_pipe;
  import cmp42_pkg::*;

  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cmp42_row_pipe_if #(.W(8),  .TAGW(TW)) b8();
  cmp42_row_pipe_if #(.W(64), .TAGW(TW)) b64();
  logic [15:0] bc8;
  logic [15:0] bc64;

  cmp42_row_pipe #(.W(8), .TAGW(TW)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b8.slave),
    .beat_cnt (bc8)
  );

  cmp42_row_pipe #(.W(64), .TAGW(TW)) u_dut64 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (b64.slave),
    .beat_cnt (bc64)
  );

  typedef struct {
    logic [7:0]    a, b, c, d;
    logic [TW-1:0] tag;
    logic [7:0]    exp;
  } vec_t;
  vec_t vec [8];

  int total = 0;
  int bad   = 0;

  // Reference model: the set of operand sums in flight, oldest first.
  logic [63:0]   q_sum [$];
  logic [TW-1:0] q_tag [$];
  int            q_cyc [$];
  logic [TW-1:0] got_tags [$];
  int cyc   = 0;
  int n_acc = 0;
  int n_dlv = 0;
  logic          hold_chk = 1'b0;
  logic [63:0]   prev_s, prev_c;
  logic [TW-1:0] prev_t;
  logic [7:0]    s8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    q_sum.delete();
    q_tag.delete();
    q_cyc.delete();
    got_tags.delete();
    hold_chk = 1'b0;
    n_acc    = 0;
    n_dlv    = 0;
  endtask

  // One clock of the W=64 DUT; entered just after a rising edge with inputs set.
  task automatic step64();
    logic exp_v, exp_r, acc, dlv;
    logic [63:0] s;
    @(negedge clk);
    exp_r = (q_sum.size() < 2) || b64.out_ready;
    exp_v = 1'b0;
    if (q_sum.size() > 0) exp_v = ((cyc - q_cyc[0]) >= 2);
    chk("in_ready", {63'd0, b64.in_ready}, {63'd0, exp_r});
    chk("out_valid", {63'd0, b64.out_valid}, {63'd0, exp_v});
    if (exp_v) begin
      s = b64.sum_row + b64.carry_row;
      chk("sum_invariant", s, q_sum[0]);
      chk("out_tag", {60'd0, b64.out_tag}, {60'd0, q_tag[0]});
    end
    if (hold_chk) begin
      chk("hold_sum", b64.sum_row, prev_s);
      chk("hold_carry", b64.carry_row, prev_c);
      chk("hold_tag", {60'd0, b64.out_tag}, {60'd0, prev_t});
    end
    chk("beat_cnt", {48'd0, bc64}, 64'(n_dlv % 65536));
    acc      = b64.in_valid && exp_r;
    dlv      = exp_v && b64.out_ready;
    hold_chk = exp_v && !b64.out_ready;
    prev_s   = b64.sum_row;
    prev_c   = b64.carry_row;
    prev_t   = b64.out_tag;
    if (dlv) got_tags.push_back(b64.out_tag);
    @(posedge clk);
    if (dlv) begin
      void'(q_sum.pop_front());
      void'(q_tag.pop_front());
      void'(q_cyc.pop_front());
      n_dlv++;
    end
    if (acc) begin
      q_sum.push_back(b64.row_a + b64.row_b + b64.row_c + b64.row_d);
      q_tag.push_back(b64.in_tag);
      q_cyc.push_back(cyc);
      n_acc++;
    end
    cyc++;
    #1;
  endtask

  task automatic rand_rows64();
    b64.row_a  = {$urandom, $urandom};
    b64.row_b  = {$urandom, $urandom};
    b64.row_c  = {$urandom, $urandom};
    b64.row_d  = {$urandom, $urandom};
    b64.in_tag = TW'($urandom_range(0, 15));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;

    vec[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'd1, 8'hFC};
    vec[1] = '{8'h01, 8'h00, 8'h00, 8'h00, 4'd2, 8'h01};
    vec[2] = '{8'h80, 8'h80, 8'h80, 8'h80, 4'd3, 8'h00};
    vec[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 4'd4, 8'h14};
    vec[4] = '{8'hAA, 8'h55, 8'hAA, 8'h55, 4'd5, 8'hFE};
    vec[5] = '{8'hFF, 8'h01, 8'h00, 8'h00, 4'd6, 8'h00};
    vec[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 4'd7, 8'h04};
    vec[7] = '{8'h7F, 8'h7F, 8'h7F, 8'h01, 4'd8, 8'h7E};

    rst_n = 1'b0;
    b8.in_valid = 1'b0;  b8.row_a = '0;  b8.row_b = '0;  b8.row_c = '0;  b8.row_d = '0;
    b8.in_tag = '0;      b8.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.row_a = '0; b64.row_b = '0; b64.row_c = '0; b64.row_d = '0;
    b64.in_tag = '0;     b64.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready64", {63'd0, b64.in_ready}, 64'd1);
    chk("rst_out_valid64", {63'd0, b64.out_valid}, 64'd0);
    chk("rst_beat64", {48'd0, bc64}, 64'd0);
    chk("rst_sum64", b64.sum_row | b64.carry_row, 64'd0);
    chk("rst_in_ready8", {63'd0, b8.in_ready}, 64'd1);
    chk("rst_out_valid8", {63'd0, b8.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // W=8 vector table, back-to-back with out_ready high: 2-cycle latency, no bubbles.
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        b8.in_valid = 1'b1;
        b8.row_a = vec[i].a; b8.row_b = vec[i].b; b8.row_c = vec[i].c; b8.row_d = vec[i].d;
        b8.in_tag = vec[i].tag;
      end else begin
        b8.in_valid = 1'b0;
      end
      @(negedge clk);
      chk("tbl_in_ready", {63'd0, b8.in_ready}, 64'd1);
      if (i >= 2) begin
        s8 = b8.sum_row + b8.carry_row;
        chk("tbl_out_valid", {63'd0, b8.out_valid}, 64'd1);
        chk("tbl_sum", {56'd0, s8}, {56'd0, vec[i-2].exp});
        chk("tbl_tag", {60'd0, b8.out_tag}, {60'd0, vec[i-2].tag});
      end else begin
        chk("tbl_latency", {63'd0, b8.out_valid}, 64'd0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("tbl_bubble", {63'd0, b8.out_valid}, 64'd0);
    chk("tbl_beat", {48'd0, bc8}, 64'd8);
    @(posedge clk);
    #1;

    // Fill while stalled: third set waits, then tags 1,2,3 in order.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    rand_rows64(); b64.in_tag = 4'd1; step64();
    rand_rows64(); b64.in_tag = 4'd2; step64();
    rand_rows64(); b64.in_tag = 4'd3; step64();
    step64();
    b64.out_ready = 1'b1;
    step64();
    b64.in_valid = 1'b0;
    repeat (4) step64();
    chk("fill_count", 64'(got_tags.size()), 64'd3);
    if (got_tags.size() == 3) begin
      chk("fill_tag0", {60'd0, got_tags[0]}, 64'd1);
      chk("fill_tag1", {60'd0, got_tags[1]}, 64'd2);
      chk("fill_tag2", {60'd0, got_tags[2]}, 64'd3);
    end

    // out_ready toggling every cycle under continuous input.
    b64.in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rand_rows64();
      b64.out_ready = k[0];
      step64();
    end
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b1;
    repeat (4) step64();

    // Reset with both stages full.
    b64.out_ready = 1'b0;
    b64.in_valid  = 1'b1;
    rand_rows64(); step64();
    rand_rows64(); step64();
    b64.in_valid = 1'b0;
    chk("pre_rst_beat_nonzero", {63'd0, (bc64 != 16'd0)}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, b64.out_valid}, 64'd0);
    chk("midrst_beat", {48'd0, bc64}, 64'd0);
    chk("midrst_in_ready", {63'd0, b64.in_ready}, 64'd1);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b64.out_ready = 1'b1;
    repeat (5) step64();

    // Random traffic and random back-pressure against the scoreboard.
    guard = 0;
    while (n_acc < 10000 && guard < 40000) begin
      b64.in_valid  = ($urandom_range(0, 9) < 8);
      b64.out_ready = ($urandom_range(0, 3) != 0);
      rand_rows64();
      step64();
      guard++;
    end
    chk("rand_accepted", 64'(n_acc), 64'd10000);
    b64.in_valid  = 1'b0;
    b64.out_ready = 1'b1;
    repeat (4) step64();
    chk("rand_drained", 64'(q_sum.size()), 64'd0);

    // Stream until 65537 deliveries since reset: counter wraps to 1.
    b64.in_valid = 1'b1;
    guard = 0;
    while (n_acc < 65537 && guard < 70000) begin
      rand_rows64();
      step64();
      guard++;
    end
    b64.in_valid = 1'b0;
    repeat (4) step64();
    chk("wrap_delivered", 64'(n_dlv), 64'd65537);
    chk("wrap_beat", {48'd0, bc64}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cmp42_row_pipe
`default_nettype wire

// File: doc/cmp42_row_pipe.md
CMP42_ROW_PIPE -- requirements
Module: cmp42_row_pipe

Interface
REQ-001 Parameter W, default 64: row width in bits; legal range 8..128.
REQ-002 Parameter TAGW, default 4: width of the sideband tag carried with each operand set.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set present on row_a..row_d and in_tag.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 row_a, row_b, row_c, row_d  input  W each  four partial-product rows of equal weight alignment.
REQ-008 in_tag  input  TAGW  sideband tag, returned unchanged with the result.
REQ-009 out_valid  output  1  result present on sum_row, carry_row and out_tag.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 sum_row, carry_row  output  W each  redundant two-row result.
REQ-012 out_tag  output  TAGW  tag of the presented result.
REQ-013 beat_cnt  output  16  count of results delivered (out_valid & out_ready).

Function
REQ-014 Stage 1 SHALL compute per bit i: s = a^b^c^d; ca = d & ~s; co = maj(a,b,c); no carry chain between bits.
REQ-015 Stage 1 SHALL register S, CA<<1 and CO<<1, truncated to W bits, plus tag, into pipeline register P1.
REQ-016 Stage 2 SHALL apply a bitwise 3:2 carry-save reduction to the three P1 rows: sum_row = x^y^z, carry_row = maj(x,y,z)<<1, truncated to W bits, registered into P2.
REQ-017 Invariant: (sum_row + carry_row) mod 2^W SHALL equal (a+b+c+d) mod 2^W for the corresponding operand set.
REQ-018 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-019 Throughput SHALL be one operand set per cycle with no bubbles while out_ready is high.
REQ-020 Stall enables: en2 = ~v2 | out_ready; en1 = ~v1 | en2; in_ready = en1. A stage loads only when its enable is high.
REQ-021 A stage whose enable is high and whose upstream holds no valid data SHALL clear its valid bit (bubble moves forward).
REQ-022 While out_valid is high and out_ready is low, sum_row, carry_row and out_tag SHALL hold stable.
REQ-023 With both stages full and out_ready low, in_ready SHALL be low and no input SHALL be accepted or lost.
REQ-024 Simultaneous accept and deliver in one cycle SHALL both occur; occupancy stays unchanged.
REQ-025 Results SHALL leave in acceptance order; tags SHALL stay paired with their data.
REQ-026 beat_cnt SHALL increment by 1 per delivery and wrap from 0xFFFF to 0x0000.
REQ-027 in_ready SHALL depend combinationally on out_ready only through REQ-020; no other combinational input-to-output path exists.

Reset
REQ-028 On rst_n low: v1, v2, out_valid = 0; beat_cnt = 0; P1/P2 data and tags = 0; in_ready = 1 while reset is asserted.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operand sets; no result appears after release.
REQ-030 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package cmp42_pkg SHALL hold the W and TAGW defaults and the 16-bit beat counter width constant.
REQ-032 One sub-module cmp42_bit SHALL implement the single-bit REQ-014 cell; the stage-1 array is W instances of it.
REQ-033 Stage 2 and the handshake logic SHALL live in cmp42_row_pipe itself.

Verification
REQ-034 W=8, a=b=c=d=0xFF, out_ready=1 -> two cycles later (sum_row+carry_row) mod 256 = 0xFC, tag echoed.
REQ-035 W=8, a=0x01, b=c=d=0x00, then a=b=c=d=0x80 back-to-back -> results sum to 0x01 then 0x00 on consecutive cycles.
REQ-036 Fill with 3 sets while out_ready=0 -> third waits with in_ready=0; release -> tags delivered in order 1,2,3, no loss.
REQ-037 Toggle out_ready every cycle with continuous input -> outputs stable while stalled; beat_cnt equals delivered count.
REQ-038 Assert rst_n low with both stages full -> out_valid=0 immediately, beat_cnt=0, no stale result after release.
REQ-039 Deliver 65537 results -> beat_cnt reads 0x0001; 10k random W=64 sets -> REQ-017 invariant holds for every result.
